obf_sub_seq: RTL and testbench
==============================

Name: obf_sub_seq

Overview:
- Sequencer that consumes the obfuscation LUT.
- Accepts fetched instructions from the IF side. An instruction flagged for obfuscation has its substitution group index latched, and the sequencer walks the pseudo program counter (ppc) through the LUT.
- For each LUT entry it merges the substitute template with the original instruction's fields and emits the result. It stops at the entry tagged LAST.
- Unflagged instructions pass straight through.
- Sits between the OR1200 fetch stage and decode, driving the LUT's index/ppc inputs and reading its sub/imm outputs.

Parameters:
- IGU_WIDTH, 4, width of substitution group index
- PPC_WIDTH, 4, width of pseudo program counter; maximum group length 2^PPC_WIDTH
- INSN_WIDTH, 32, instruction width
- LUT_OUT_WIDTH, 33, LUT word width = INSN_WIDTH+1 (MSB of sub word = LAST flag)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-low
- in_valid  in  1  fetched instruction valid
- in_ready  out  1  sequencer accepts instruction this cycle
- in_insn  in  INSN_WIDTH  fetched instruction
- in_obf  in  1  instruction must be substituted
- in_index  in  IGU_WIDTH  substitution group index from IGU
- lut_index  out  IGU_WIDTH  index to LUT
- lut_ppc  out  PPC_WIDTH  ppc to LUT
- lut_sub  in  LUT_OUT_WIDTH  LUT substitute word: [32]=LAST, [31:0]=template
- lut_imm  in  LUT_OUT_WIDTH  LUT field mask: [31:0] ones select original-instruction bits; [32] ignored
- out_valid  out  1  emitted instruction valid
- out_ready  in  1  downstream accepts
- out_insn  out  INSN_WIDTH  emitted instruction
- out_last  out  1  final instruction of a group (1 for passthrough)
- busy  out  1  state is SEQ

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, ppc=0, idx=0, orig=0, out_valid=0, out_insn=0, out_last=0. Reset mid-sequence abandons the group; nothing further is emitted.
- Output register advance: adv = !out_valid || out_ready. While out_valid && !out_ready, out_insn and out_last hold stable.
- in_ready = (state==IDLE) && adv. Handshake completes when in_valid && in_ready.
- IDLE, accept with in_obf=0:
  - next cycle out_valid=1, out_insn=in_insn, out_last=1.
  - Latency 1; throughput 1/cycle.
- IDLE, accept with in_obf=1:
  - orig<=in_insn, idx<=in_index, ppc<=0, state<=SEQ.
  - out_valid<=0 unless held by stall.
  - Nothing is emitted that cycle from the new instruction.
- IDLE, no accept: if out_ready, out_valid<=0.
- lut_index = idx and lut_ppc = ppc at all times; the LUT is combinational.
- SEQ, adv=1:
  - out_insn <= (lut_sub[31:0] & ~lut_imm[31:0]) | (orig & lut_imm[31:0]).
  - out_valid<=1.
  - end = lut_sub[32] || (ppc == 2^PPC_WIDTH-1); out_last<=end.
  - If end, state<=IDLE and ppc<=0; else ppc<=ppc+1.
- SEQ, adv=0: hold all state; ppc does not advance.
- First substituted instruction appears 2 cycles after acceptance.
- An N-entry group emits exactly N outputs, one per cycle, when out_ready is held high.
- ppc never wraps. At the maximum ppc the group is force-terminated with out_last=1.
- in_ready=0 for the whole SEQ state, including the cycle the LAST entry is emitted. The next instruction is accepted the cycle after return to IDLE.
- busy = (state==SEQ).

Test Plan:
- Reset: hold rst=0 for 2 cycles with in_valid=1 -> out_valid=0, out_insn=0, in_ready=0 during reset; in_ready=1 first cycle after release.
- Passthrough: in_insn=0x15000000, in_obf=0, out_ready=1, back-to-back for 4 cycles -> out_insn equals each input 1 cycle later, out_last=1, no bubbles.
- Substitution, 3-entry group: index=2; LUT entries sub={0,0xA0000000},{0,0xB0000000},{1,0xC0000000}; imm=0x0000FFFF; in_insn=0x9C21ABCD:
  - outputs 0xA000ABCD, 0xB000ABCD, 0xC000ABCD on cycles t+2..t+4, out_last only on the third.
  - lut_ppc goes 0,1,2.
  - in_ready returns to 1 at t+5.
- Backpressure: same group with out_ready low for 3 cycles after the first output -> out_insn held at 0xA000ABCD and lut_ppc held at 1; sequence resumes without loss or duplication.
- Overflow guard: LUT with LAST never set, PPC_WIDTH=4 -> exactly 16 outputs, the 16th with out_last=1, then IDLE.
- Reset mid-group: assert rst=0 after the 2nd output -> out_valid=0 and busy=0 next cycle; a following passthrough instruction is emitted normally.

Source files
------------

// File: rtl/obf_sub_seq.sv
// Obfuscation substitution sequencer between fetch and decode.
// Flagged instructions are replaced by their LUT group; the others pass straight through.
module obf_sub_seq #(
  parameter int IGU_WIDTH     = 4,
  parameter int PPC_WIDTH     = 4,
  parameter int INSN_WIDTH    = 32,
  parameter int LUT_OUT_WIDTH = INSN_WIDTH + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INSN_WIDTH-1:0]    in_insn,
  input  logic                     in_obf,
  input  logic [IGU_WIDTH-1:0]     in_index,
  output logic [IGU_WIDTH-1:0]     lut_index,
  output logic [PPC_WIDTH-1:0]     lut_ppc,
  input  logic [LUT_OUT_WIDTH-1:0] lut_sub,
  input  logic [LUT_OUT_WIDTH-1:0] lut_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INSN_WIDTH-1:0]    out_insn,
  output logic                     out_last,
  output logic                     busy
);

  // state | meaning
  // IDLE  | accepting fetched instructions; passthrough goes out directly
  // SEQ   | walking ppc through the LUT group of the latched instruction
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEQ  = 1'b1;

  logic [0:0]            state;
  logic [PPC_WIDTH-1:0]  ppc;
  logic [IGU_WIDTH-1:0]  idx;
  logic [INSN_WIDTH-1:0] orig;
  logic                  adv;
  logic                  seq_end;
  logic [INSN_WIDTH-1:0] merged;
  logic                  unused_imm_msb;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = rst && (state == IDLE) && adv;
  assign lut_index = idx;
  assign lut_ppc   = ppc;
  assign busy      = (state == SEQ);

  // Mask ones keep fields of the original instruction, zeros take the template.
  assign merged  = (lut_sub[INSN_WIDTH-1:0] & ~lut_imm[INSN_WIDTH-1:0]) |
                   (orig & lut_imm[INSN_WIDTH-1:0]);
  // The last ppc value force-terminates the group so ppc never wraps.
  assign seq_end = lut_sub[LUT_OUT_WIDTH-1] || (ppc == {PPC_WIDTH{1'b1}});

  assign unused_imm_msb = lut_imm[LUT_OUT_WIDTH-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      ppc       <= '0;
      idx       <= '0;
      orig      <= '0;
      out_valid <= 1'b0;
      out_insn  <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            if (in_obf) begin
              orig      <= in_insn;
              idx       <= in_index;
              ppc       <= '0;
              state     <= SEQ;
              out_valid <= 1'b0;
            end else begin
              out_valid <= 1'b1;
              out_insn  <= in_insn;
              out_last  <= 1'b1;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        SEQ: begin
          if (adv) begin
            out_valid <= 1'b1;
            out_insn  <= merged;
            out_last  <= seq_end;
            if (seq_end) begin
              state <= IDLE;
              ppc   <= '0;
            end else begin
              ppc <= ppc + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obf_sub_seq.sv
// Directed bench for obf_sub_seq: passthrough table, 3-entry group, stall,
// ppc overflow guard and mid-group reset.
module tb_obf_sub_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_insn;
  logic        in_obf;
  logic [3:0]  in_index;
  logic [3:0]  lut_index;
  logic [3:0]  lut_ppc;
  logic [32:0] lut_sub;
  logic [32:0] lut_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_insn;
  logic        out_last;
  logic        busy;

  int errors = 0;
  int checks = 0;

  obf_sub_seq dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn),
    .in_obf(in_obf), .in_index(in_index),
    .lut_index(lut_index), .lut_ppc(lut_ppc),
    .lut_sub(lut_sub), .lut_imm(lut_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_insn(out_insn), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  // Group 2 is three entries long; every other group never sets LAST.
  always_comb begin
    lut_imm = {1'b0, 32'h0000FFFF};
    lut_sub = {1'b0, lut_ppc, 28'h0};
    if (lut_index == 4'd2) begin
      case (lut_ppc)
        4'd0:    lut_sub = {1'b0, 32'hA0000000};
        4'd1:    lut_sub = {1'b0, 32'hB0000000};
        4'd2:    lut_sub = {1'b1, 32'hC0000000};
        default: lut_sub = {1'b1, 32'h00000000};
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        v;
    logic [31:0] insn;
    logic        rdy;
    logic        exp_in_ready;
    logic        exp_v;
    logic [31:0] exp_insn;
  } vec_t;

  vec_t tbl[10];

  task automatic start_group(input logic [3:0] index, input logic [31:0] insn);
    in_valid = 1'b1; in_obf = 1'b1; in_index = index; in_insn = insn; out_ready = 1'b1;
    chk("grp_accept_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; in_obf = 1'b0;
    chk("grp_busy", 32'(busy), 32'd1);
    chk("grp_ready_low", 32'(in_ready), 32'd0);
    chk("grp_no_out", 32'(out_valid), 32'd0);
    chk("grp_lut_index", 32'(lut_index), 32'(index));
    chk("grp_ppc0", 32'(lut_ppc), 32'd0);
  endtask

  int n_out;
  logic last_seen;
  logic [31:0] last_insn;

  initial begin
    tbl[0] = '{1'b1, 32'h15000000, 1'b1, 1'b1, 1'b1, 32'h15000000};
    tbl[1] = '{1'b1, 32'h15000000, 1'b1, 1'b1, 1'b1, 32'h15000000};
    tbl[2] = '{1'b1, 32'h12345678, 1'b1, 1'b1, 1'b1, 32'h12345678};
    tbl[3] = '{1'b1, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF};
    tbl[4] = '{1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF};
    tbl[5] = '{1'b1, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b1, 32'hA5A5A5A5};
    tbl[6] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'hA5A5A5A5};
    tbl[7] = '{1'b1, 32'h0F0F0F0F, 1'b0, 1'b1, 1'b1, 32'h0F0F0F0F};
    tbl[8] = '{1'b1, 32'h11111111, 1'b0, 1'b0, 1'b1, 32'h0F0F0F0F};
    tbl[9] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0F0F0F0F};

    rst = 1'b0; in_valid = 1'b1; in_insn = 32'hDEADBEEF; in_obf = 1'b0;
    in_index = 4'd0; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_insn", out_insn, 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Passthrough / handshake table: each row is driven, then checked after one edge.
    for (int i = 0; i < 10; i++) begin
      in_valid = tbl[i].v; in_insn = tbl[i].insn; in_obf = 1'b0; out_ready = tbl[i].rdy;
      #1;
      chk($sformatf("pt%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].exp_in_ready));
      tick();
      chk($sformatf("pt%0d_valid", i), 32'(out_valid), 32'(tbl[i].exp_v));
      chk($sformatf("pt%0d_insn", i), out_insn, tbl[i].exp_insn);
      chk($sformatf("pt%0d_last", i), 32'(out_last), 32'd1);
    end

    // Three-entry group without stalls.
    in_valid = 1'b0; out_ready = 1'b1;
    start_group(4'd2, 32'h9C21ABCD);
    tick();
    chk("g3_o1_valid", 32'(out_valid), 32'd1);
    chk("g3_o1_insn", out_insn, 32'hA000ABCD);
    chk("g3_o1_last", 32'(out_last), 32'd0);
    chk("g3_ppc1", 32'(lut_ppc), 32'd1);
    chk("g3_o1_ready", 32'(in_ready), 32'd0);
    tick();
    chk("g3_o2_insn", out_insn, 32'hB000ABCD);
    chk("g3_o2_last", 32'(out_last), 32'd0);
    chk("g3_ppc2", 32'(lut_ppc), 32'd2);
    chk("g3_o2_ready", 32'(in_ready), 32'd0);
    tick();
    chk("g3_o3_valid", 32'(out_valid), 32'd1);
    chk("g3_o3_insn", out_insn, 32'hC000ABCD);
    chk("g3_o3_last", 32'(out_last), 32'd1);
    tick();
    chk("g3_t5_ready", 32'(in_ready), 32'd1);
    chk("g3_t5_valid", 32'(out_valid), 32'd0);
    chk("g3_t5_busy", 32'(busy), 32'd0);

    // Same group with out_ready low for three cycles after the first output.
    start_group(4'd2, 32'h9C21ABCD);
    tick();
    chk("bp_o1_insn", out_insn, 32'hA000ABCD);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_insn", out_insn, 32'hA000ABCD);
      chk("bp_hold_last", 32'(out_last), 32'd0);
      chk("bp_hold_ppc", 32'(lut_ppc), 32'd1);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_o2_insn", out_insn, 32'hB000ABCD);
    chk("bp_o2_last", 32'(out_last), 32'd0);
    tick();
    chk("bp_o3_insn", out_insn, 32'hC000ABCD);
    chk("bp_o3_last", 32'(out_last), 32'd1);
    tick();
    chk("bp_idle_busy", 32'(busy), 32'd0);
    chk("bp_idle_valid", 32'(out_valid), 32'd0);

    // LAST never set: the group must stop by itself after 16 entries.
    start_group(4'd5, 32'h12345678);
    n_out = 0; last_seen = 1'b0; last_insn = '0;
    for (int i = 0; i < 40 && !last_seen; i++) begin
      tick();
      if (out_valid) begin
        n_out++;
        last_seen = out_last;
        last_insn = out_insn;
      end
    end
    chk("ovf_count", 32'(n_out), 32'd16);
    chk("ovf_last", 32'(last_seen), 32'd1);
    chk("ovf_final_insn", last_insn, 32'hF0005678);
    tick();
    chk("ovf_idle_busy", 32'(busy), 32'd0);
    chk("ovf_idle_ready", 32'(in_ready), 32'd1);

    // Reset after the second output of a group, then a normal passthrough.
    start_group(4'd2, 32'h9C21ABCD);
    tick();
    tick();
    chk("mr_o2_insn", out_insn, 32'hB000ABCD);
    rst = 1'b0;
    tick();
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    in_valid = 1'b1; in_obf = 1'b0; in_insn = 32'h15000000; out_ready = 1'b1;
    #1;
    chk("mr_pt_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("mr_pt_valid", 32'(out_valid), 32'd1);
    chk("mr_pt_insn", out_insn, 32'h15000000);
    chk("mr_pt_last", 32'(out_last), 32'd1);
    tick();
    chk("mr_pt_drain", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
